bus_grant_arbiter: RTL



---
 rtl/bus_grant_arbiter_pkg.sv | 46 ++++
 rtl/bus_grant_arbiter_rr_pick.sv | 38 +++
 rtl/bus_grant_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/bus_grant_arbiter_pkg.sv
// Shared types and constants for the CPU bus grant arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_grant_arbiter_pkg;

  localparam int N_DEF     = 24;
  localparam int SEL_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Bus source indices as seen on the req/gnt vectors.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Folds an index in [0, 2n) back into [0, n); cheaper than a modulo.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Round-robin winner search: first set req bit at or after last_owner+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the winner.
module bus_grant_arbiter_rr_pick
  import bus_grant_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_owner,
  output logic [N-1:0]     winner_oh,
  output logic [SEL_W-1:0] winner_idx,
  output logic             any
);

  logic [N-1:0] rot;
  int           start;
  int           first;

  // Rotate so the search start sits at bit 0, find the lowest set bit, then map back.
  always_comb begin
    start = wrap_idx(int'(last_owner) + 1, N);
    rot   = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[SEL_W'(wrap_idx(start + i, N))];
    end
    any   = |rot;
    first = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = i;
    end
    winner_idx = any ? SEL_W'(wrap_idx(start + first, N)) : '0;
    winner_oh  = '0;
    if (any) winner_oh[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin owner select for the shared CPU bus with a dead turnaround cycle and a hold cap.
// Latency: grant registered one edge after req is seen in IDLE/TURN; release costs one zero cycle.
// Backpressure: requesters hold req until served; a waiting requester forces preemption after MAX_HOLD cycles.
module bus_grant_arbiter
  import bus_grant_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             bus_valid,
  output logic             owner_changed
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              bus_valid_q, bus_valid_d;
  logic              owner_changed_q, owner_changed_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]  last_owner_q, last_owner_d;

  logic [N-1:0]      pick_oh;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic              others_pending;

  bus_grant_arbiter_rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  assign others_pending = |(req & ~gnt_q);

  // Next-state and next-output logic; outputs are all staged here and registered together.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    sel_d           = sel_q;
    bus_valid_d     = bus_valid_q;
    owner_changed_d = 1'b0;
    hold_cnt_d      = hold_cnt_q;
    last_owner_d    = last_owner_q;

    case (state_q)
      ST_GRANT: begin
        // Release and forced preemption take the same path into the dead cycle.
        if (!req[sel_q] || ((hold_cnt_q == HOLD_LAST) && others_pending)) begin
          state_d     = ST_TURN;
          gnt_d       = '0;
          sel_d       = '0;
          bus_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        // IDLE and TURN behave alike: bus is unowned, grant the next winner if any.
        if (pick_any) begin
          state_d         = ST_GRANT;
          gnt_d           = pick_oh;
          sel_d           = pick_idx;
          bus_valid_d     = 1'b1;
          owner_changed_d = 1'b1;
          hold_cnt_d      = '0;
          last_owner_d    = pick_idx;
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          sel_d       = '0;
          bus_valid_d = 1'b0;
        end
      end
    endcase
  end

  // State and output registers; clr wins over every input.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q         <= ST_IDLE;
      gnt_q           <= '0;
      sel_q           <= '0;
      bus_valid_q     <= 1'b0;
      owner_changed_q <= 1'b0;
      hold_cnt_q      <= '0;
      last_owner_q    <= SEL_W'(N - 1);
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      sel_q           <= sel_d;
      bus_valid_q     <= bus_valid_d;
      owner_changed_q <= owner_changed_d;
      hold_cnt_q      <= hold_cnt_d;
      last_owner_q    <= last_owner_d;
    end
  end

  assign gnt           = gnt_q;
  assign sel           = sel_q;
  assign bus_valid     = bus_valid_q;
  assign owner_changed = owner_changed_q;

endmodule
